// File: rtl/cr_sa_snap_ctl.sv
// Snapshot/clear sequencer for a bank of N_CNT event counters.
// Software commands or a periodic timer strobe the counters' snap/clear
// lines, then every snapshot register is streamed out as two 32-bit beats
// (low word, then zero-extended high word) over a valid/ready interface.
module cr_sa_snap_ctl #(
    parameter int N_CNT = 16,
    parameter int CNT_W = 50
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    input  logic [1:0]               cmd_op,
    output logic                     cmd_ready,
    input  logic [31:0]              snap_interval,
    output logic [N_CNT-1:0]         sa_snap,
    output logic [N_CNT-1:0]         sa_clear,
    input  logic [N_CNT*CNT_W-1:0]   sa_snapshot_bus,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [31:0]              rd_data,
    output logic [5:0]               rd_idx,
    output logic                     rd_hi,
    output logic                     rd_last,
    output logic                     rd_auto,
    output logic                     busy,
    output logic [7:0]               auto_miss
);

    localparam logic [1:0] OP_NOP    = 2'd0;
    localparam logic [6:0] LAST_BEAT = 7'(2 * N_CNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        SETTLE,
        DUMP
    } state_t;

    state_t             state;
    logic               op_snap;     // latched op[0]: a dump follows the strobe
    logic               auto_q;      // current operation was timer-triggered
    logic [6:0]         beat;        // beat currently presented on rd_*
    logic [31:0]        timer;
    logic               auto_pend;

    logic               timer_expire;
    logic               auto_take;
    logic [6:0]         nxt_beat;
    logic [CNT_W-1:0]   nxt_word;
    logic [31:0]        nxt_data;

    assign cmd_ready = (state == IDLE) && !auto_pend;
    assign busy      = (state != IDLE);
    assign auto_take = (state == IDLE) && auto_pend;

    // Timer expiry; compared in 33 bits so an interval of 2^32-1 cannot wrap.
    always_comb begin
        // NOTE: every combinational output gets a value before any branch, so no latch is inferred.
        timer_expire = 1'b0;
        if (snap_interval != 32'd0) begin
            timer_expire = ({1'b0, timer} + 33'd1) >= {1'b0, snap_interval};
        end
    end

    // Select the word for the beat to be presented next (beat 0 when entering DUMP).
    always_comb begin
        nxt_beat = (state == DUMP) ? beat + 7'd1 : 7'd0;
        nxt_word = '0;
        for (int k = 0; k < N_CNT; k++) begin
            if (nxt_beat[6:1] == 6'(k)) begin
                nxt_word = sa_snapshot_bus[k*CNT_W +: CNT_W];
            end
        end
        nxt_data = nxt_beat[0] ? 32'(nxt_word >> 32) : nxt_word[31:0];
    end

    // Free-running auto-snapshot timer, pending flag and saturating miss counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (rst) begin
            timer     <= '0;
            auto_pend <= 1'b0;
            auto_miss <= '0;
        end else begin
            if (snap_interval == 32'd0 || timer_expire) begin
                timer <= '0;
            end else begin
                timer <= timer + 32'd1;
            end

            if (timer_expire && !auto_pend) begin
                auto_pend <= 1'b1;
            end else if (auto_take) begin
                auto_pend <= 1'b0;
            end

            if (timer_expire && auto_pend && auto_miss != 8'hFF) begin
                auto_miss <= auto_miss + 8'd1;
            end
        end
    end

    // Main sequencer with registered strobe and readout outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_snap  <= 1'b0;
            auto_q   <= 1'b0;
            beat     <= '0;
            sa_snap  <= '0;
            sa_clear <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_idx   <= '0;
            rd_hi    <= 1'b0;
            rd_last  <= 1'b0;
            rd_auto  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (auto_pend) begin
                        state    <= STROBE;
                        op_snap  <= 1'b1;
                        auto_q   <= 1'b1;
                        sa_snap  <= '1;
                        sa_clear <= '0;
                    end else if (cmd_valid && cmd_op != OP_NOP) begin
                        state    <= STROBE;
                        op_snap  <= cmd_op[0];
                        auto_q   <= 1'b0;
                        sa_snap  <= {N_CNT{cmd_op[0]}};
                        sa_clear <= {N_CNT{cmd_op[1]}};
                    end
                end

                STROBE: begin
                    sa_snap  <= '0;
                    sa_clear <= '0;
                    state    <= op_snap ? SETTLE : IDLE;
                end

                // Snapshot registers captured at the end of STROBE; load beat 0.
                SETTLE: begin
                    state    <= DUMP;
                    beat     <= nxt_beat;
                    rd_valid <= 1'b1;
                    rd_data  <= nxt_data;
                    rd_idx   <= nxt_beat[6:1];
                    rd_hi    <= nxt_beat[0];
                    rd_last  <= (nxt_beat == LAST_BEAT);
                    rd_auto  <= auto_q;
                end

                DUMP: begin
                    if (rd_ready) begin
                        if (beat == LAST_BEAT) begin
                            state    <= IDLE;
                            beat     <= '0;
                            rd_valid <= 1'b0;
                            rd_data  <= '0;
                            rd_idx   <= '0;
                            rd_hi    <= 1'b0;
                            rd_last  <= 1'b0;
                            rd_auto  <= 1'b0;
                        end else begin
                            beat    <= nxt_beat;
                            rd_data <= nxt_data;
                            rd_idx  <= nxt_beat[6:1];
                            rd_hi   <= nxt_beat[0];
                            rd_last <= (nxt_beat == LAST_BEAT);
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cr_sa_snap_ctl.sv
// Self-checking bench for cr_sa_snap_ctl: a counter-bank environment,
// a table of command vectors, timer/reset corner sequences and randomized
// commands with backpressure checked against an array-based model.
module tb_cr_sa_snap_ctl;

    localparam int N  = 16;
    localparam int W  = 50;
    localparam int NB = 2 * N;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cmd_valid = 1'b0;
    logic [1:0]         cmd_op = 2'd0;
    logic               cmd_ready;
    logic [31:0]        snap_interval = 32'd0;
    logic [N-1:0]       sa_snap;
    logic [N-1:0]       sa_clear;
    logic [N*W-1:0]     bus;
    logic               rd_valid;
    logic               rd_ready = 1'b1;
    logic [31:0]        rd_data;
    logic [5:0]         rd_idx;
    logic               rd_hi;
    logic               rd_last;
    logic               rd_auto;
    logic               busy;
    logic [7:0]         auto_miss;

    cr_sa_snap_ctl #(.N_CNT(N), .CNT_W(W)) dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_op          (cmd_op),
        .cmd_ready       (cmd_ready),
        .snap_interval   (snap_interval),
        .sa_snap         (sa_snap),
        .sa_clear        (sa_clear),
        .sa_snapshot_bus (bus),
        .rd_valid        (rd_valid),
        .rd_ready        (rd_ready),
        .rd_data         (rd_data),
        .rd_idx          (rd_idx),
        .rd_hi           (rd_hi),
        .rd_last         (rd_last),
        .rd_auto         (rd_auto),
        .busy            (busy),
        .auto_miss       (auto_miss)
    );

    always #5 clk = ~clk;

    // Counter bank environment: snapshot registers capture on sa_snap, clear wins over load.
    logic [W-1:0] env_cnt  [N];
    logic [W-1:0] env_snap [N];
    logic [W-1:0] load_val [N];
    logic         load_en = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (sa_snap[i]) env_snap[i] <= env_cnt[i];
            if (sa_clear[i]) env_cnt[i] <= '0;
            else if (load_en) env_cnt[i] <= load_val[i];
        end
    end

    always_comb begin
        bus = '0;
        for (int i = 0; i < N; i++) bus[i*W +: W] = env_snap[i];
    end

    // Reference model: counter contents and the values a dump must show.
    logic [W-1:0] mdl_cnt  [N];
    logic [W-1:0] exp_snap [N];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [63:0] exp_beat(input int b, input logic au);
        logic [W-1:0] v;
        logic [63:0]  v64;
        logic [31:0]  d;
        v   = exp_snap[b / 2];
        v64 = 64'(v);
        d   = (b % 2 == 1) ? v64[63:32] : v64[31:0];
        return {23'd0, au, 1'(b == NB - 1), 1'(b % 2 == 1), 6'(b / 2), d};
    endfunction

    task automatic preload(input logic [W-1:0] base, input bit rnd);
        logic [W-1:0] v;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            v = rnd ? W'({$urandom, $urandom}) : W'(base + W'(i) * W'(64'h1_0000_0001));
            load_val[i] = v;
            mdl_cnt[i]  = v;
        end
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Consume a dump starting at the current negedge; rd_valid must already be high.
    task automatic collect_dump(input bit bp, input logic au,
                                output logic [31:0] lo0, output logic [31:0] hi0);
        int          b = 0;
        int          cyc = 0;
        bit          stalled = 0;
        logic [63:0] cur;
        logic [63:0] prev = '0;
        lo0 = '0;
        hi0 = '0;
        while (b < NB) begin
            if (cyc > 2000) begin
                check("dump_timeout", 64'(b), 64'(NB));
                break;
            end
            cur = {23'd0, rd_auto, rd_last, rd_hi, rd_idx, rd_data};
            check("rd_valid_in_dump", 64'(rd_valid), 64'd1);
            if (rd_valid !== 1'b1) break;
            if (stalled) check("stall_stable", cur, prev);
            rd_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rd_ready) begin
                check($sformatf("beat%0d", b), cur, exp_beat(b, au));
                if (b == 0) lo0 = rd_data;
                if (b == 1) hi0 = rd_data;
                b++;
                stalled = 0;
            end else begin
                stalled = 1;
                prev    = cur;
            end
            @(negedge clk);
            cyc++;
        end
        rd_ready = 1'b1;
        check("dump_end_rd_valid", 64'(rd_valid), 64'd0);
    endtask

    // Issue one command from IDLE and follow it through strobe and optional dump.
    task automatic do_op(input logic [1:0] op, input bit bp,
                         input logic [N-1:0] ss, input logic [N-1:0] cs,
                         output logic [31:0] lo0, output logic [31:0] hi0);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("strobes_t1", 64'({sa_snap, sa_clear}), 64'({ss, cs}));
        if (op[0]) exp_snap = mdl_cnt;
        if (op[1]) for (int i = 0; i < N; i++) mdl_cnt[i] = '0;
        @(negedge clk);
        check("strobes_t2", 64'({sa_snap, sa_clear}), 64'd0);
        check("ctl_t2", 64'({cmd_ready, busy, rd_valid}), 64'({!op[0], op[0], 1'b0}));
        lo0 = '0;
        hi0 = '0;
        if (op[0]) begin
            @(negedge clk);
            collect_dump(bp, 1'b0, lo0, hi0);
        end
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] val;
        logic [N-1:0] snap_s;
        logic [N-1:0] clr_s;
        bit           dump;
        logic [31:0]  lo0;
        logic [31:0]  hi0;
        logic [W-1:0] after0;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [31:0] lo, hi;
        int          iv, ne, q, exp_miss, n_bad;
        logic [1:0]  op;

        vecs[0] = '{2'd1, 50'd5,                16'hFFFF, 16'h0000, 1'b1, 32'h0000_0005, 32'h0000_0000, 50'd5};
        vecs[1] = '{2'd2, 50'h1234,             16'h0000, 16'hFFFF, 1'b0, 32'h0000_0000, 32'h0000_0000, 50'd0};
        vecs[2] = '{2'd3, 50'h3_FFFF_FFFF_FFFF, 16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFF_FFFF, 32'h0003_FFFF, 50'd0};
        vecs[3] = '{2'd0, 50'd7,                16'h0000, 16'h0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 50'd7};
        vecs[4] = '{2'd1, 50'h2_0000_0000_0001, 16'hFFFF, 16'h0000, 1'b1, 32'h0000_0001, 32'h0002_0000, 50'h2_0000_0000_0001};

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset_ctl", 64'({cmd_ready, busy, rd_valid, rd_last, rd_auto, rd_hi, rd_idx, auto_miss}),
              64'({1'b1, 5'd0, 6'd0, 8'd0}));
        check("reset_data", 64'(rd_data), 64'd0);
        check("reset_strobes", 64'({sa_snap, sa_clear}), 64'd0);
        rst = 1'b0;

        // Table-driven command vectors.
        for (int v = 0; v < 5; v++) begin
            preload(vecs[v].val, 1'b0);
            do_op(vecs[v].op, 1'b0, vecs[v].snap_s, vecs[v].clr_s, lo, hi);
            if (vecs[v].dump) begin
                check($sformatf("vec%0d_lo0", v), 64'(lo), 64'(vecs[v].lo0));
                check($sformatf("vec%0d_hi0", v), 64'(hi), 64'(vecs[v].hi0));
            end else begin
                check($sformatf("vec%0d_idle", v), 64'({busy, rd_valid}), 64'd0);
            end
            check($sformatf("vec%0d_cnt0", v), 64'(env_cnt[0]), 64'(vecs[v].after0));
        end

        // Auto-snapshot timer with the sink stalled.
        iv = $urandom_range(4, 12);
        ne = $urandom_range(3 * iv, 80);
        q  = ne / iv;
        exp_miss = (q > 2) ? q - 2 : 0;
        if (exp_miss > 255) exp_miss = 255;
        preload('0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        snap_interval = 32'(iv);
        rd_ready = 1'b0;
        repeat (ne) @(negedge clk);
        check("auto_miss_stalled", 64'(auto_miss), 64'(exp_miss));
        check("auto_dump_stalled", 64'({busy, rd_valid, rd_auto, rd_hi, rd_idx}),
              64'({1'b1, 1'b1, 1'b1, 1'b0, 6'd0}));
        snap_interval = 32'd0;
        exp_snap = mdl_cnt;
        collect_dump(1'b1, 1'b1, lo, hi);
        // Still pending from the second expiry: the timer beats a waiting command.
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        check("cmd_ready_auto_wins", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        check("auto_strobe", 64'({sa_snap, sa_clear}), 64'({{N{1'b1}}, {N{1'b0}}}));
        repeat (2) @(negedge clk);
        collect_dump(1'b0, 1'b1, lo, hi);
        check("cmd_ready_after_auto", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("held_cmd_clear", 64'({sa_snap, sa_clear}), 64'({{N{1'b0}}, {N{1'b1}}}));
        for (int i = 0; i < N; i++) mdl_cnt[i] = '0;
        check("auto_miss_hold", 64'(auto_miss), 64'(exp_miss));

        // Reset in the middle of a dump, at beat 7.
        preload('0, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        rd_ready = 1'b1;
        repeat (7) @(negedge clk);
        check("beat7_pos", 64'({rd_valid, rd_idx, rd_hi}), 64'({1'b1, 6'd3, 1'b1}));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_dump", 64'({rd_valid, busy, cmd_ready, rd_last}), 64'({1'b0, 1'b0, 1'b1, 1'b0}));
        check("rst_auto_miss", 64'(auto_miss), 64'd0);

        // Randomized commands with 50% backpressure.
        for (int r = 0; r < 12; r++) begin
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) preload('0, 1'b1);
            do_op(op, 1'b1, {N{op[0]}}, {N{op[1]}}, lo, hi);
            n_bad = 0;
            for (int i = 0; i < N; i++) if (env_cnt[i] !== mdl_cnt[i]) n_bad++;
            check($sformatf("rnd%0d_cnt_model", r), 64'(n_bad), 64'd0);
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule
